// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter
// Shares the single read port of the cellular RAM controller among NREQ
// requesters. It grants one requester at a time in round-robin order and
// drives that requester's address to the controller. A fixed-latency
// down-counter sets the sample point. The captured 16-bit word is returned
// with a one-cycle rd_valid strobe.
//
// Optional build macro: RAM_ARB_FIXED_PRI_EN
//   When defined, requester 0 (VGA scanline fetch) always wins. The remaining
//   requesters share round-robin among themselves, and the last-served
//   pointer only advances on grants to requesters 1..NREQ-1.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no read in flight; arbitrate over req
// S_WAIT | address driven, latency counter running down to the sample point
// S_DONE | data captured, rd_valid strobe for the granted requester

module ram_read_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 26,
  parameter int READ_LAT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rd_valid,
  output logic [15:0]              rd_data,
  output logic                     busy,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [15:0]              mem_db
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last, last_nxt;
  logic [IDX_W-1:0]  cur, cur_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [NREQ-1:0]   rd_valid_nxt;
  logic [15:0]       rd_data_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [NREQ-1:0]   cand;
  logic [IDX_W-1:0]  scan_idx;
  int                scan_pos;

  // Winner selection: scan from last+1 upward with wrap-around.
  // In the fixed-priority build, requester 0 pre-empts the scan and is
  // masked out of the rotation.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = req;
    scan_pos  = 0;
    scan_idx  = '0;
`ifdef RAM_ARB_FIXED_PRI_EN
    cand[0] = 1'b0;
    if (req[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
    for (int off = 1; off <= NREQ; off++) begin
      scan_pos = int'(last) + off;
      if (scan_pos >= NREQ) begin
        scan_pos = scan_pos - NREQ;
      end
      scan_idx = IDX_W'(scan_pos);
      if (!sel_found && cand[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> WAIT -> DONE sequence.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    cur_nxt      = cur;
    cnt_nxt      = cnt;
    gnt_nxt      = gnt;
    rd_valid_nxt = '0;
    rd_data_nxt  = rd_data;
    ram_addr_nxt = ram_addr;

    case (state)
      S_IDLE: begin
        if (sel_found) begin
          state_nxt = S_WAIT;
          cur_nxt   = sel_idx;
          cnt_nxt   = CNT_LOAD;
          for (int i = 0; i < NREQ; i++) begin
            gnt_nxt[i] = (sel_idx == IDX_W'(i));
            if (sel_idx == IDX_W'(i)) begin
              ram_addr_nxt = req_addr[i*ADDR_W +: ADDR_W];
            end
          end
        end
      end

      S_WAIT: begin
        if (cnt == '0) begin
          // Sample point: the controller has had READ_LAT cycles since the
          // address went out. The strobe is registered alongside the data so
          // that both appear together in DONE.
          rd_data_nxt  = mem_db;
          rd_valid_nxt = gnt;
          state_nxt    = S_DONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      S_DONE: begin
        gnt_nxt   = '0;
        state_nxt = S_IDLE;
`ifdef RAM_ARB_FIXED_PRI_EN
        if (cur != '0) begin
          last_nxt = cur;
        end
`else
        last_nxt = cur;
`endif
      end

      default: begin
        gnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer, counter and registered outputs; reset aborts any read
  // in flight without a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      last     <= LAST_INIT;
      cur      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      ram_addr <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      cur      <= cur_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
      ram_addr <= ram_addr_nxt;
    end
  end

  // busy follows the state register directly so reset clears it at once.
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed testbench for ram_read_arbiter (NREQ=3, ADDR_W=26, READ_LAT=8).
// Builds with or without RAM_ARB_FIXED_PRI_EN; the arbitration-order
// expectations follow the macro.

module tb_ram_read_arbiter;

  localparam int NREQ     = 3;
  localparam int ADDR_W   = 26;
  localparam int READ_LAT = 8;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [15:0]            rd_data;
  logic                   busy;
  logic [ADDR_W-1:0]      ram_addr;
  logic [15:0]            mem_db;

  int n_checks = 0;
  int n_err    = 0;

  ram_read_arbiter #(
    .NREQ     (NREQ),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .ram_addr (ram_addr),
    .mem_db   (mem_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so a broken build can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addrs(input logic [25:0] a0, input logic [25:0] a1, input logic [25:0] a2);
    req_addr = {a2, a1, a0};
  endtask

  // One full transaction, starting in an IDLE cycle whose req selects idx.
  // Returns in the IDLE cycle that follows DONE.
  task automatic serve(input int idx, input logic [25:0] addr, input logic [15:0] data);
    logic [2:0] oh;
    bit         ok;
    oh     = 3'b001 << idx;
    mem_db = data;
    tick();
    check("grant", {29'd0, gnt}, {29'd0, oh});
    check("ram_addr", {6'd0, ram_addr}, {6'd0, addr});
    check("busy_wait", {31'd0, busy}, 32'd1);
    ok = 1'b1;
    for (int c = 0; c < READ_LAT - 1; c++) begin
      tick();
      if (gnt !== oh || ram_addr !== addr || rd_valid !== 3'b000 || busy !== 1'b1) ok = 1'b0;
    end
    check("wait_stable", {31'd0, ok}, 32'd1);
    tick();
    check("rd_valid", {29'd0, rd_valid}, {29'd0, oh});
    check("rd_data", {16'd0, rd_data}, {16'd0, data});
    tick();
    check("rd_valid_clear", {29'd0, rd_valid}, 32'd0);
    check("gnt_clear", {29'd0, gnt}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    bit bad;

    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    mem_db   = '0;
    tick();
    tick();

    // Reset state.
    check("rst_gnt", {29'd0, gnt}, 32'd0);
    check("rst_rd_valid", {29'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_ram_addr", {6'd0, ram_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_no_req_gnt", {29'd0, gnt}, 32'd0);

    // Single requester 0.
    set_addrs(26'h0000100, 26'h0, 26'h0);
    req = 3'b001;
    serve(0, 26'h0000100, 16'hABCD);
    req = 3'b000;
    tick();
    check("after_single_gnt", {29'd0, gnt}, 32'd0);
    check("hold_ram_addr", {6'd0, ram_addr}, 32'h100);

    // Restore the pointer so requester 0 is first again.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // All three requesting.
    set_addrs(26'h10, 26'h20, 26'h30);
    req = 3'b111;
`ifdef RAM_ARB_FIXED_PRI_EN
    serve(0, 26'h10, 16'hC000);
    serve(0, 26'h10, 16'hC001);
    serve(0, 26'h10, 16'hC002);
    serve(0, 26'h10, 16'hC003);
`else
    serve(0, 26'h10, 16'hC000);
    serve(1, 26'h20, 16'hC001);
    serve(2, 26'h30, 16'hC002);
    serve(0, 26'h10, 16'hC003);
`endif
    // Requester 0 backs off: 1 and 2 alternate.
    req = 3'b110;
    serve(1, 26'h20, 16'hC004);
    serve(2, 26'h30, 16'hC005);
    serve(1, 26'h20, 16'hC006);
    req = 3'b000;

    // Requester 1 drops its request three cycles into service.
    req    = 3'b010;
    mem_db = 16'h7777;
    tick();
    check("drop_grant", {29'd0, gnt}, 32'b010);
    tick();
    tick();
    tick();
    req    = 3'b000;
    pulses = 0;
    bad    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd_valid === 3'b010) pulses++;
      else if (rd_valid !== 3'b000) bad = 1'b1;
      if (gnt !== 3'b000 && gnt !== 3'b010) bad = 1'b1;
    end
    check("drop_pulse_count", pulses, 32'd1);
    check("drop_no_stray", {31'd0, bad}, 32'd0);
    check("drop_rd_data", {16'd0, rd_data}, 32'h7777);
    check("drop_idle_gnt", {29'd0, gnt}, 32'd0);
    check("drop_idle_busy", {31'd0, busy}, 32'd0);

    // Sample point and grant-time address capture.
    set_addrs(26'h0ABC, 26'h20, 26'h30);
    mem_db = 16'hDEAD;
    req    = 3'b001;
    tick();
    tick();
    tick();
    set_addrs(26'h3FFFFFF, 26'h20, 26'h30);
    tick();
    tick();
    tick();
    tick();
    mem_db = 16'h1234;
    tick();
    tick();
    check("samp_rd_valid", {29'd0, rd_valid}, 32'b001);
    check("samp_rd_data", {16'd0, rd_data}, 32'h1234);
    check("samp_addr_latched", {6'd0, ram_addr}, 32'h0ABC);
    mem_db = 16'h5678;
    req    = 3'b000;
    tick();
    check("samp_rd_data_hold", {16'd0, rd_data}, 32'h1234);
    check("samp_rd_valid_clear", {29'd0, rd_valid}, 32'd0);

    // Reset in the middle of WAIT (counter at 4).
    set_addrs(26'h55, 26'h20, 26'h3AB);
    req    = 3'b100;
    mem_db = 16'hBEEF;
    tick();
    check("mid_grant", {29'd0, gnt}, 32'b100);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #2;
    check("mid_rst_gnt", {29'd0, gnt}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ram_addr", {6'd0, ram_addr}, 32'd0);
    check("mid_rst_rd_valid", {29'd0, rd_valid}, 32'd0);
    check("mid_rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    req = 3'b101;
    serve(0, 26'h55, 16'h4242);
    req = 3'b000;
    tick();
    check("end_idle_gnt", {29'd0, gnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
